root_power_arbiter: RTL and testbench

Per-bank arbiter that shares the ROOT_POWER_NUM root-power (twiddle W/WQ) RAM banks among the NTT_INTT_NUM NTT/INTT units. It grants exclusive burst ownership of one bank to one requesting unit and drives the interconnect steering selects `root_select` and `ntt_intt_select`. After each burst it holds a drain gap so that in-flight read data leaves the registered interconnect before the bank switches owner.

---
 rtl/root_power_arbiter_if.sv | 33 +++
 rtl/root_power_arbiter.sv | 131 +++++++++++++
 tb/tb_root_power_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/root_power_arbiter_if.sv
// rtl/root_power_arbiter_if.sv - request/grant and steering bundle for root_power_arbiter
// ROOT_ARB_PERF_CNT_EN adds the per-bank grant_cnt field.
interface root_power_arbiter_if #(
  parameter int NTT_NUM  = 4,
  parameter int ROOT_NUM = 4,
  parameter int LEN_W    = 12
) ();
  localparam int BANK_W = (ROOT_NUM > 1) ? $clog2(ROOT_NUM) : 1;
  localparam int NTT_W  = (NTT_NUM > 1) ? $clog2(NTT_NUM) : 1;

  logic [NTT_NUM-1:0]              req;
  logic [NTT_NUM-1:0][BANK_W-1:0]  req_bank;
  logic [NTT_NUM-1:0][LEN_W-1:0]   req_len;
  logic [NTT_NUM-1:0]              gnt;
  logic [NTT_NUM-1:0]              done;
  logic [NTT_NUM-1:0][BANK_W-1:0]  root_select;
  logic [ROOT_NUM-1:0][NTT_W-1:0]  ntt_intt_select;
  logic [ROOT_NUM-1:0]             bank_busy;

`ifdef ROOT_ARB_PERF_CNT_EN
  logic [ROOT_NUM-1:0][15:0]       grant_cnt;

  modport master (output req, req_bank, req_len,
                  input  gnt, done, root_select, ntt_intt_select, bank_busy, grant_cnt);
  modport slave  (input  req, req_bank, req_len,
                  output gnt, done, root_select, ntt_intt_select, bank_busy, grant_cnt);
`else
  modport master (output req, req_bank, req_len,
                  input  gnt, done, root_select, ntt_intt_select, bank_busy);
  modport slave  (input  req, req_bank, req_len,
                  output gnt, done, root_select, ntt_intt_select, bank_busy);
`endif
endinterface

// File: rtl/root_power_arbiter.sv
// rtl/root_power_arbiter.sv - per-bank burst arbiter sharing root-power RAM banks among NTT/INTT units
// Optional ROOT_ARB_PERF_CNT_EN: per-bank saturating completed-burst counters on grant_cnt.
module root_power_arbiter #(
  parameter int NTT_NUM    = 4,
  parameter int ROOT_NUM   = 4,
  parameter int LEN_W      = 12,
  parameter int SWITCH_GAP = 2
) (
  input  logic clk,
  input  logic rst,
  root_power_arbiter_if.slave bus
);
  localparam int BANK_W = (ROOT_NUM > 1) ? $clog2(ROOT_NUM) : 1;
  localparam int NTT_W  = (NTT_NUM > 1) ? $clog2(NTT_NUM) : 1;
  localparam int GAP_W  = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t                          state [ROOT_NUM];
  logic [LEN_W-1:0]                cnt   [ROOT_NUM];
  logic [GAP_W-1:0]                gap   [ROOT_NUM];
  logic [NTT_W-1:0]                ptr   [ROOT_NUM];
  logic [NTT_W-1:0]                pick  [ROOT_NUM];
  logic [ROOT_NUM-1:0]             free;
  logic [ROOT_NUM-1:0]             pick_vld;
  logic [ROOT_NUM-1:0]             busy;
  logic [NTT_W-1:0]                cand;
  logic [NTT_NUM-1:0]              gnt_q;
  logic [NTT_NUM-1:0]              done_q;
  logic [NTT_NUM-1:0][BANK_W-1:0]  root_sel_q;
  logic [ROOT_NUM-1:0][NTT_W-1:0]  ntt_sel_q;
`ifdef ROOT_ARB_PERF_CNT_EN
  logic [ROOT_NUM-1:0][15:0]       grant_cnt_q;
`endif

  function automatic logic [NTT_W-1:0] wrap_idx(input logic [NTT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NTT_NUM) s = s - NTT_NUM;
    return NTT_W'(s);
  endfunction

  // The last DRAIN cycle (or last BUSY cycle with no gap) arbitrates directly,
  // so the next owner's first beat follows the gap with no extra idle cycle.
  always_comb begin
    cand = '0;
    for (int b = 0; b < ROOT_NUM; b++) begin
      free[b] = (state[b] == IDLE) ||
                (state[b] == DRAIN && gap[b] == '0) ||
                (SWITCH_GAP == 0 && state[b] == BUSY && cnt[b] == '0);
      busy[b]     = (state[b] != IDLE);
      pick_vld[b] = 1'b0;
      pick[b]     = '0;
      for (int k = NTT_NUM - 1; k >= 0; k--) begin
        cand = wrap_idx(ptr[b], k);
        if (bus.req[cand] && !gnt_q[cand] && bus.req_bank[cand] == BANK_W'(b)) begin
          pick_vld[b] = 1'b1;
          pick[b]     = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q      <= '0;
      done_q     <= '0;
      root_sel_q <= '0;
      ntt_sel_q  <= '0;
`ifdef ROOT_ARB_PERF_CNT_EN
      grant_cnt_q <= '0;
`endif
      for (int b = 0; b < ROOT_NUM; b++) begin
        state[b] <= IDLE;
        cnt[b]   <= '0;
        gap[b]   <= '0;
        ptr[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < ROOT_NUM; b++) begin
        case (state[b])
          BUSY: begin
            if (cnt[b] == '0) begin
              gnt_q[ntt_sel_q[b]]  <= 1'b0;
              done_q[ntt_sel_q[b]] <= 1'b0;
`ifdef ROOT_ARB_PERF_CNT_EN
              if (grant_cnt_q[b] != 16'hFFFF) grant_cnt_q[b] <= grant_cnt_q[b] + 16'd1;
`endif
              if (SWITCH_GAP == 0) begin
                state[b] <= IDLE;
              end else begin
                state[b] <= DRAIN;
                gap[b]   <= GAP_W'(SWITCH_GAP - 1);
              end
            end else begin
              cnt[b]               <= cnt[b] - LEN_W'(1);
              done_q[ntt_sel_q[b]] <= (cnt[b] == LEN_W'(1));
            end
          end
          DRAIN: begin
            if (gap[b] == '0) state[b] <= IDLE;
            else              gap[b]   <= gap[b] - GAP_W'(1);
          end
          default: ;
        endcase

        // A new grant never targets the unit this bank just released: it still has gnt=1.
        if (free[b] && pick_vld[b]) begin
          state[b]             <= BUSY;
          ntt_sel_q[b]         <= pick[b];
          root_sel_q[pick[b]]  <= BANK_W'(b);
          gnt_q[pick[b]]       <= 1'b1;
          done_q[pick[b]]      <= (bus.req_len[pick[b]] <= LEN_W'(1));
          cnt[b]               <= (bus.req_len[pick[b]] == '0) ? '0
                                  : bus.req_len[pick[b]] - LEN_W'(1);
          ptr[b]               <= (pick[b] == NTT_W'(NTT_NUM - 1)) ? '0 : pick[b] + NTT_W'(1);
        end
      end
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.done            = done_q;
  assign bus.root_select     = root_sel_q;
  assign bus.ntt_intt_select = ntt_sel_q;
  assign bus.bank_busy       = busy;
`ifdef ROOT_ARB_PERF_CNT_EN
  assign bus.grant_cnt       = grant_cnt_q;
`endif

endmodule

// File: tb/tb_root_power_arbiter.sv
// tb/tb_root_power_arbiter.sv - scoreboard bench for root_power_arbiter
module tb_root_power_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  root_power_arbiter_if #(.NTT_NUM(4), .ROOT_NUM(4), .LEN_W(12)) u_if ();
  root_power_arbiter #(.NTT_NUM(4), .ROOT_NUM(4), .LEN_W(12), .SWITCH_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if.slave));

  // Three banks in a two-bit field leave bank code 3 out of range.
  root_power_arbiter_if #(.NTT_NUM(2), .ROOT_NUM(3), .LEN_W(12)) u_if3 ();
  root_power_arbiter #(.NTT_NUM(2), .ROOT_NUM(3), .LEN_W(12), .SWITCH_GAP(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(u_if3.slave));

  typedef struct { int unit; int bank; int start; int len; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c;
  int rises_before;
  logic [3:0] stim_req = '0;
  int raise_id [4] = '{0, 0, 0, 0};
  int taken_id [4] = '{0, 0, 0, 0};
  int run [4]      = '{0, 0, 0, 0};
  int exp_len [4]  = '{0, 0, 0, 0};
  int rises [4]    = '{0, 0, 0, 0};
  int g3 [2]       = '{0, 0};
  logic [3:0] active   = '0;
  logic [3:0] prev_gnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int u = 0; u < 4; u++) u_if.req[u] = stim_req[u] && (raise_id[u] != taken_id[u]);
  end

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic raise(input int u, input int bank, input int len);
    u_if.req_bank[u] = 2'(bank);
    u_if.req_len[u]  = 12'(len);
    raise_id[u]++;
    stim_req[u] = 1'b1;
  endtask

  task automatic push(input int u, input int bank, input int start, input int len);
    exp_q.push_back('{u, bank, start, len});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active != '0 || u_if.bank_busy != '0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) check_eq("wait_idle_timeout", n, -1);
  endtask

  // Monitor: pops an expected burst on each gnt rise, checks its length and done placement.
  always @(negedge clk) begin
    if (rst) begin
      active   = '0;
      prev_gnt = u_if.gnt;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (u_if.gnt[u] && !prev_gnt[u]) begin
          rises[u]++;
          taken_id[u] = raise_id[u];
          if (exp_q.size() == 0) begin
            check_eq("unexpected_gnt", u, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check_eq("gnt_unit", u, mon_e.unit);
            check_eq("gnt_start", cyc, mon_e.start);
            check_eq("root_select", u_if.root_select[u], mon_e.bank);
            check_eq("ntt_intt_select", u_if.ntt_intt_select[mon_e.bank], u);
            check_eq("bank_busy_on_gnt", u_if.bank_busy[mon_e.bank], 1);
            active[u]  = 1'b1;
            run[u]     = 0;
            exp_len[u] = mon_e.len;
          end
        end
        if (u_if.gnt[u]) begin
          run[u]++;
          if (u_if.done[u] || run[u] == exp_len[u])
            check_eq("done_last_beat", u_if.done[u], run[u] == exp_len[u]);
        end else begin
          if (u_if.done[u]) check_eq("done_without_gnt", 1, 0);
          if (prev_gnt[u] && active[u]) begin
            check_eq("burst_len", run[u], exp_len[u]);
            active[u] = 1'b0;
          end
        end
      end
      prev_gnt = u_if.gnt;
    end
  end

  always @(negedge clk) begin
    if (!rst) for (int u = 0; u < 2; u++) g3[u] += int'(u_if3.gnt[u]);
  end

  initial begin
    u_if.req_bank  = '0;
    u_if.req_len   = '0;
    u_if3.req      = '0;
    u_if3.req_bank = '0;
    u_if3.req_len  = '0;
    tick(3);
    check_eq("rst_gnt", u_if.gnt, 0);
    check_eq("rst_done", u_if.done, 0);
    check_eq("rst_bank_busy", u_if.bank_busy, 0);
    check_eq("rst_root_select", u_if.root_select, 0);
    check_eq("rst_ntt_intt_select", u_if.ntt_intt_select, 0);
    rst = 1'b0;
    tick(2);

    // single burst: unit 1, bank 2, 5 beats, then a two-cycle drain
    c = cyc;
    raise(1, 2, 5);
    push(1, 2, c + 1, 5);
    tick(7);
    check_eq("single_busy_drain", u_if.bank_busy[2], 1);
    check_eq("single_hold_sel", u_if.ntt_intt_select[2], 1);
    tick(1);
    check_eq("single_busy_end", u_if.bank_busy[2], 0);
    wait_idle(20);

    // contention on bank 0 from units 0, 2, 3
    tick(1);
    c = cyc;
    raise(0, 0, 3);
    raise(2, 0, 3);
    raise(3, 0, 3);
    push(0, 0, c + 1, 3);
    push(2, 0, c + 6, 3);
    push(3, 0, c + 11, 3);
    wait_idle(60);

    // pointer wrapped to 0 after unit 3, so unit 1 beats unit 3
    tick(1);
    c = cyc;
    raise(3, 0, 1);
    raise(1, 0, 1);
    push(1, 0, c + 1, 1);
    push(3, 0, c + 4, 1);
    wait_idle(30);

    // parallel banks
    tick(1);
    c = cyc;
    for (int u = 0; u < 4; u++) begin
      raise(u, 3 - u, 4);
      push(u, 3 - u, c + 1, 4);
    end
    wait_idle(30);
    check_eq("parallel_ntt_sel", u_if.ntt_intt_select, 8'h1B);
    check_eq("parallel_root_sel", u_if.root_select, 8'h1B);

    // length edges: 0 acts as 1, 4095 is the maximum
    tick(1);
    c = cyc;
    raise(2, 1, 0);
    raise(3, 3, 4095);
    push(2, 1, c + 1, 1);
    push(3, 3, c + 1, 4095);
    wait_idle(4200);

    // withdrawal while bank 1 is busy
    tick(1);
    c = cyc;
    rises_before = rises[2];
    raise(0, 1, 6);
    push(0, 1, c + 1, 6);
    tick(2);
    raise(2, 1, 2);
    tick(1);
    stim_req[2] = 1'b0;
    wait_idle(40);
    tick(5);
    check_eq("withdrawn_no_gnt", rises[2], rises_before);

    // out-of-range bank on the three-bank instance
    u_if3.req_bank[0] = 2'd2;
    u_if3.req_len[0]  = 12'd2;
    u_if3.req_bank[1] = 2'd3;
    u_if3.req_len[1]  = 12'd2;
    u_if3.req         = 2'b11;
    tick(1);
    u_if3.req[0] = 1'b0;
    tick(30);
    check_eq("range_inrange_beats", g3[0], 2);
    check_eq("range_oob_beats", g3[1], 0);
    check_eq("range_bank_busy", u_if3.bank_busy, 0);
    u_if3.req = '0;

    // reset during beat 3 of an 8-beat burst
    tick(1);
    c = cyc;
    raise(0, 0, 8);
    push(0, 0, c + 1, 8);
    tick(3);
    rst = 1'b1;
    tick(1);
    check_eq("abort_gnt", u_if.gnt, 0);
    check_eq("abort_done", u_if.done, 0);
    check_eq("abort_bank_busy", u_if.bank_busy, 0);
    check_eq("abort_root_select", u_if.root_select, 0);
    check_eq("abort_ntt_intt_select", u_if.ntt_intt_select, 0);
`ifdef ROOT_ARB_PERF_CNT_EN
    check_eq("abort_grant_cnt", u_if.grant_cnt, 0);
`endif
    rst = 1'b0;
    tick(1);
    c = cyc;
    raise(1, 0, 2);
    push(1, 0, c + 1, 2);
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
